// File: rtl/reset_seq_pkg.sv
// Shared types and encodings for the staged reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    RELEASE,
    HOLD,
    DONE
  } state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctech_mux2x1_4.sv
// Behavioural view of the technology 2:1 mux cell used on reset bypass paths.
module ctech_mux2x1_4 (
  input  logic i0,
  input  logic i1,
  input  logic s,
  output logic z
);

  assign z = s ? i1 : i0;

endmodule

// File: rtl/reset_seq.sv
// Staged reset sequencer: releases NUM_STAGES resets in order, re-applies a partial
// reset on SW/WDT request, scan bypass to arst_n. Optional cause register: RESET_SEQ_CAUSE_EN.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned STAGE_DLY  = 16,
  parameter int unsigned HOLD_CYC   = 8,
  parameter int unsigned SW_FIRST   = 1
) (
  input  logic                  dclk,
  input  logic                  arst_n,
  input  logic                  scan_mode,
  input  logic                  sw_rst_req,
  input  logic                  wdt_rst_req,
  output logic [NUM_STAGES-1:0] rst_n_o,
  output logic                  rst_ack,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            rst_cause
);

  localparam int unsigned CW = $clog2(max_u(STAGE_DLY, HOLD_CYC));
  localparam int unsigned SW = $clog2(NUM_STAGES) + 1;
  // Stages below SW_FIRST survive a SW/WDT reset.
  localparam logic [NUM_STAGES-1:0] KEEP_MASK = NUM_STAGES'((64'd1 << SW_FIRST) - 64'd1);

  state_e                state_q, state_d;
  logic [SW-1:0]         stage_q, stage_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d;
  logic                  ack_q, ack_d;
  logic                  req;

  assign req = sw_rst_req | wdt_rst_req;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    ack_d   = 1'b0;
    case (state_q)
      RELEASE: begin
        if (cnt_q == CW'(STAGE_DLY - 1)) begin
          cnt_d   = '0;
          stage_d = stage_q + 1'b1;
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (stage_q == SW'(i)) rst_d[i] = 1'b1;
          end
          if (stage_q == SW'(NUM_STAGES - 1)) state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYC - 1)) begin
          state_d = RELEASE;
          stage_d = SW'(SW_FIRST);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (req) begin
          state_d = HOLD;
          cnt_d   = '0;
          ack_d   = 1'b1;
          rst_d   = rst_q & KEEP_MASK;
        end
      end
      default: state_d = RELEASE;
    endcase
  end

  always_ff @(posedge dclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RELEASE;
      stage_q <= '0;
      cnt_q   <= '0;
      rst_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ack_q   <= ack_d;
    end
  end

  assign rst_ack = ack_q;
  assign busy    = (state_q != DONE);
  assign done    = (state_q == DONE);

`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0] cause_q, cause_d;

  always_comb begin
    cause_d = cause_q;
    if (state_q == DONE && req) cause_d = wdt_rst_req ? CAUSE_WDT : CAUSE_SW;
  end

  always_ff @(posedge dclk or negedge arst_n) begin
    if (!arst_n) cause_q <= CAUSE_POR;
    else         cause_q <= cause_d;
  end

  assign rst_cause = cause_q;
`else
  assign rst_cause = CAUSE_POR;
`endif

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_scan
    ctech_mux2x1_4 u_mux (
      .i0 (rst_q[g]),
      .i1 (arst_n),
      .s  (scan_mode),
      .z  (rst_n_o[g])
    );
  end

endmodule
